ffsr_pulse_seq: RTL and testbench

//  Sequencer that drives one ffsr_pulse register (pulse/thermometer-coded value) to a requested target.

---
 rtl/ffsr_pkg.sv | 32 +++
 rtl/ffsr_therm_decode.sv | 39 +++
 rtl/ffsr_pulse_seq.sv | 159 +++++++++++++++
 tb/tb_ffsr_pulse_seq.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ffsr_pkg.sv
// Shared types and helpers for the ffsr pulse-domain blocks: sequencer state,
// completion status and the binary-to-thermometer encoder.
package ffsr_pkg;

    localparam int FFSR_W_MAX = 64;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_LWAIT = 3'd2,
        ST_STEP  = 3'd3,
        ST_SWAIT = 3'd4,
        ST_DONE  = 3'd5
    } seq_state_e;

    typedef struct packed {
        logic err;
        logic sat;
        logic aborted;
    } seq_status_t;

    // Callers truncate the result to their own register width.
    function automatic logic [FFSR_W_MAX-1:0] therm_of(input int n);
        logic [FFSR_W_MAX-1:0] code;
        code = {FFSR_W_MAX{1'b0}};
        for (int i = 0; i < FFSR_W_MAX; i++) begin
            code[i] = (i < n);
        end
        return code;
    endfunction

endpackage

// File: rtl/ffsr_therm_decode.sv
// Combinational thermometer decoder: counts contiguous ones from bit 0 and
// flags any pattern that is not a legal thermometer code.
module ffsr_therm_decode
    import ffsr_pkg::*;
#(
    parameter int INPUT_SIZE = 8,
    parameter int CNT_W      = $clog2(INPUT_SIZE + 1)
) (
    input  logic [INPUT_SIZE-1:0] therm_in,
    output logic [CNT_W-1:0]      count,
    output logic                  therm_err
);

    logic [CNT_W-1:0]      count_s;
    logic                  run_s;
    logic [INPUT_SIZE-1:0] legal_s;

    // Run-length of ones starting at the LSB; the first zero ends the run.
    always_comb begin
        count_s = {CNT_W{1'b0}};
        run_s   = 1'b1;
        for (int i = 0; i < INPUT_SIZE; i++) begin
            if (run_s && therm_in[i]) begin
                count_s = count_s + {{(CNT_W-1){1'b0}}, 1'b1};
            end else begin
                run_s = 1'b0;
            end
        end
    end

    // Re-encode the count and compare, catching stray ones above the run.
    always_comb begin
        legal_s = INPUT_SIZE'(therm_of(int'(count_s)));
    end

    assign count     = count_s;
    assign therm_err = (therm_in != legal_s);

endmodule

// File: rtl/ffsr_pulse_seq.sv
// Drives one ffsr_pulse register to a binary target, either by direct load or
// by single-unit inc/dec steps, closing the loop through the decoded feedback.
module ffsr_pulse_seq
    import ffsr_pkg::*;
#(
    parameter int INPUT_SIZE = 8,
    parameter int CNT_W      = $clog2(INPUT_SIZE + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [CNT_W-1:0]      req_target,
    input  logic                  req_load,
    input  logic                  abort,
    input  logic [INPUT_SIZE-1:0] therm_in,
    output logic                  ffsr_rst,
    output logic [INPUT_SIZE-1:0] ffsr_init,
    output logic                  ffsr_inc,
    output logic                  ffsr_dec,
    output logic [CNT_W-1:0]      count,
    output logic                  therm_err,
    output logic                  busy,
    output logic                  done,
    output logic [2:0]            status
);

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(INPUT_SIZE);

    seq_state_e            state_r, state_nxt_s;
    logic [CNT_W-1:0]      target_q_r, target_nxt_s, target_clamp_s;
    seq_status_t           status_r, status_nxt_s;
    logic                  ffsr_rst_r, ffsr_rst_nxt_s;
    logic [INPUT_SIZE-1:0] ffsr_init_r, ffsr_init_nxt_s;
    logic                  ffsr_inc_r, ffsr_inc_nxt_s;
    logic                  ffsr_dec_r, ffsr_dec_nxt_s;
    logic                  done_r, done_nxt_s;
    logic                  sat_s;
    logic [CNT_W-1:0]      count_s;
    logic                  therm_err_s;

    ffsr_therm_decode #(
        .INPUT_SIZE (INPUT_SIZE),
        .CNT_W      (CNT_W)
    ) u_decode (
        .therm_in  (therm_in),
        .count     (count_s),
        .therm_err (therm_err_s)
    );

    assign sat_s          = (req_target > MAX_CNT);
    assign target_clamp_s = sat_s ? MAX_CNT : req_target;

    // Next-state and next-output decode; pulse outputs are decided one cycle
    // ahead so they leave the block straight from flops.
    always_comb begin
        state_nxt_s     = state_r;
        target_nxt_s    = target_q_r;
        status_nxt_s    = status_r;
        ffsr_rst_nxt_s  = 1'b0;
        ffsr_init_nxt_s = ffsr_init_r;
        ffsr_inc_nxt_s  = 1'b0;
        ffsr_dec_nxt_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (req_valid) begin
                    target_nxt_s         = target_clamp_s;
                    status_nxt_s.err     = 1'b0;
                    status_nxt_s.sat     = sat_s;
                    status_nxt_s.aborted = 1'b0;
                    if (req_load) begin
                        state_nxt_s     = ST_LOAD;
                        ffsr_rst_nxt_s  = 1'b1;
                        ffsr_init_nxt_s = INPUT_SIZE'(therm_of(int'(target_clamp_s)));
                    end else begin
                        state_nxt_s = ST_STEP;
                    end
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_LOAD: begin
                state_nxt_s = ST_LWAIT;
            end
            ST_LWAIT: begin
                status_nxt_s.err = therm_err_s || (count_s != target_q_r);
                state_nxt_s      = ST_DONE;
            end
            ST_STEP: begin
                if (abort) begin
                    status_nxt_s.aborted = 1'b1;
                    state_nxt_s          = ST_DONE;
                end else if (therm_err_s) begin
                    status_nxt_s.err = 1'b1;
                    state_nxt_s      = ST_DONE;
                end else if (count_s < target_q_r) begin
                    ffsr_inc_nxt_s = 1'b1;
                    state_nxt_s    = ST_SWAIT;
                end else if (count_s > target_q_r) begin
                    ffsr_dec_nxt_s = 1'b1;
                    state_nxt_s    = ST_SWAIT;
                end else begin
                    state_nxt_s = ST_DONE;
                end
            end
            ST_SWAIT: begin
                if (abort) begin
                    status_nxt_s.aborted = 1'b1;
                    state_nxt_s          = ST_DONE;
                end else begin
                    state_nxt_s = ST_STEP;
                end
            end
            ST_DONE: begin
                state_nxt_s = ST_IDLE;
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    assign done_nxt_s = (state_nxt_s == ST_DONE);

    // State, target and output registers; reset cuts any pulse in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r     <= ST_IDLE;
            target_q_r  <= {CNT_W{1'b0}};
            status_r    <= 3'b000;
            ffsr_rst_r  <= 1'b0;
            ffsr_init_r <= {INPUT_SIZE{1'b0}};
            ffsr_inc_r  <= 1'b0;
            ffsr_dec_r  <= 1'b0;
            done_r      <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            target_q_r  <= target_nxt_s;
            status_r    <= status_nxt_s;
            ffsr_rst_r  <= ffsr_rst_nxt_s;
            ffsr_init_r <= ffsr_init_nxt_s;
            ffsr_inc_r  <= ffsr_inc_nxt_s;
            ffsr_dec_r  <= ffsr_dec_nxt_s;
            done_r      <= done_nxt_s;
        end
    end

    assign req_ready = (state_r == ST_IDLE);
    assign busy      = (state_r != ST_IDLE);
    assign ffsr_rst  = ffsr_rst_r;
    assign ffsr_init = ffsr_init_r;
    assign ffsr_inc  = ffsr_inc_r;
    assign ffsr_dec  = ffsr_dec_r;
    assign done      = done_r;
    assign status    = status_r;
    assign count     = count_s;
    assign therm_err = therm_err_s;

endmodule

// File: tb/tb_ffsr_pulse_seq.sv
// Scoreboard bench for ffsr_pulse_seq driving a behavioural ffsr_pulse register.
module tb_ffsr_pulse_seq;

    localparam int N = 8;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          ffsr_por_n = 1'b0;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic [CW-1:0] req_target = 4'd0;
    logic          req_load = 1'b0;
    logic          abort = 1'b0;
    logic [N-1:0]  therm_in;
    logic          ffsr_rst;
    logic [N-1:0]  ffsr_init;
    logic          ffsr_inc;
    logic          ffsr_dec;
    logic [CW-1:0] count;
    logic          therm_err;
    logic          busy;
    logic          done;
    logic [2:0]    status;

    logic [N-1:0]  ffsr_q;
    logic          force_en = 1'b0;
    logic [N-1:0]  force_val = 8'h00;

    typedef struct {
        int         lat;
        logic [2:0] st;
        logic [7:0] therm;
        int         cnt;
        logic       terr;
        int         incs;
        int         decs;
        int         rsts;
        logic [7:0] init;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    int   done_seen = 0;
    int   acc_cyc = 0;
    int   n_inc = 0, n_dec = 0, n_rst = 0, last_pulse = -1;
    int   ref_val = 0;

    ffsr_pulse_seq #(.INPUT_SIZE(N), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_target(req_target), .req_load(req_load), .abort(abort),
        .therm_in(therm_in), .ffsr_rst(ffsr_rst), .ffsr_init(ffsr_init),
        .ffsr_inc(ffsr_inc), .ffsr_dec(ffsr_dec), .count(count),
        .therm_err(therm_err), .busy(busy), .done(done), .status(status)
    );

    always #5 clk = ~clk;

    // Behavioural ffsr_pulse with its own power-on reset.
    always @(posedge clk or negedge ffsr_por_n) begin
        if (!ffsr_por_n) ffsr_q <= 8'h00;
        else if (ffsr_rst) ffsr_q <= ffsr_init;
        else if (ffsr_inc) ffsr_q <= {ffsr_q[N-2:0], 1'b1};
        else if (ffsr_dec) ffsr_q <= {1'b0, ffsr_q[N-1:1]};
    end

    assign therm_in = force_en ? force_val : ffsr_q;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] req);
        checks++;
        if (got !== req) begin
            failures++;
            $display("FAIL %s got=%0d required=%0d", name, got, req);
        end
    endtask

    task automatic note_fail(input string name);
        checks++;
        failures++;
        $display("FAIL %s got=event required=none", name);
    endtask

    function automatic exp_t model_req(int cur, int tgt, bit ld);
        exp_t e;
        int t;
        t = (tgt > N) ? N : tgt;
        e.therm = 8'((1 << t) - 1);
        e.cnt   = t;
        e.terr  = 1'b0;
        e.st    = {1'b0, (tgt > N), 1'b0};
        if (ld) begin
            e.lat = 3; e.incs = 0; e.decs = 0; e.rsts = 1; e.init = e.therm;
        end else begin
            e.lat  = 2 * ((t > cur) ? t - cur : cur - t) + 2;
            e.incs = (t > cur) ? t - cur : 0;
            e.decs = (cur > t) ? cur - t : 0;
            e.rsts = 0;
            e.init = 8'h00;
        end
        return e;
    endfunction

    // Monitor: tracks pulses per transaction and scores each done against the queue head.
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            n_inc = 0; n_dec = 0; n_rst = 0; last_pulse = -1;
        end else begin
            if (req_valid && req_ready) begin
                acc_cyc = cyc; n_inc = 0; n_dec = 0; n_rst = 0; last_pulse = -1;
            end
            if (ffsr_inc || ffsr_dec) begin
                chk("inc_dec_exclusive", 32'(ffsr_inc & ffsr_dec), 32'd0);
                if (last_pulse >= 0) chk("pulse_gap", cyc - last_pulse, 2);
                last_pulse = cyc;
                if (ffsr_inc) n_inc++;
                if (ffsr_dec) n_dec++;
            end
            if (ffsr_rst) begin
                n_rst++;
                if (exp_q.size() > 0) chk("ffsr_init", 32'(ffsr_init), 32'(exp_q[0].init));
            end
            if (done) begin
                if (exp_q.size() == 0) begin
                    note_fail("unexpected_done");
                end else begin
                    e = exp_q.pop_front();
                    chk("latency", cyc - acc_cyc, e.lat);
                    chk("status", 32'(status), 32'(e.st));
                    chk("therm_in", 32'(therm_in), 32'(e.therm));
                    chk("count", 32'(count), e.cnt);
                    chk("therm_err", 32'(therm_err), 32'(e.terr));
                    chk("inc_pulses", n_inc, e.incs);
                    chk("dec_pulses", n_dec, e.decs);
                    chk("rst_pulses", n_rst, e.rsts);
                end
                done_seen++;
            end
        end
    end

    task automatic issue(input int tgt, input bit ld, input exp_t e);
        int n = 0;
        while (!req_ready && n < 100) begin
            @(posedge clk); #2;
            n++;
        end
        if (!req_ready) note_fail("ready_timeout");
        exp_q.push_back(e);
        req_valid = 1'b1; req_target = 4'(tgt); req_load = ld;
        @(posedge clk); #2;
        req_valid = 1'b0;
    endtask

    task automatic wait_done(input int start);
        int n = 0;
        while (done_seen == start && n < 100) begin
            @(posedge clk); #2;
            n++;
        end
        if (done_seen == start) note_fail("done_timeout");
    endtask

    task automatic run_req(input int tgt, input bit ld);
        int start;
        start = done_seen;
        issue(tgt, ld, model_req(ref_val, tgt, ld));
        wait_done(start);
        ref_val = (tgt > N) ? N : tgt;
    endtask

    initial begin
        exp_t e;
        int   start, n, k;
        repeat (3) @(posedge clk);
        #2; rst = 1'b1; ffsr_por_n = 1'b1;
        @(negedge clk);
        chk("reset_ready", 32'(req_ready), 32'd1);
        chk("reset_done", 32'(done), 32'd0);
        chk("reset_status", 32'(status), 32'd0);
        chk("reset_outputs", 32'({ffsr_rst, ffsr_inc, ffsr_dec, ffsr_init}), 32'd0);

        // Reset mid-step while an inc pulse is high.
        @(posedge clk); #2;
        issue(4, 1'b0, model_req(0, 4, 1'b0));
        n = 0;
        while (!ffsr_inc && n < 20) begin
            @(posedge clk); #2;
            n++;
        end
        if (!ffsr_inc) note_fail("inc_never_seen");
        rst = 1'b0;
        #1;
        chk("rst_cuts_inc", 32'(ffsr_inc), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        exp_q.delete();
        @(posedge clk); #2;
        @(posedge clk); #2;
        rst = 1'b1;
        @(negedge clk);
        chk("post_rst_ready", 32'(req_ready), 32'd1);
        chk("post_rst_done", 32'(done), 32'd0);
        chk("post_rst_status", 32'(status), 32'd0);
        chk("post_rst_count", 32'(count), 32'd0);
        ref_val = 0;

        run_req(5, 1'b1);           // load 5
        run_req(2, 1'b0);           // step 5 -> 2
        run_req(6, 1'b0);           // step 2 -> 6
        run_req(12, 1'b0);          // step 6 -> clamp 8

        // Illegal thermometer feedback during STEP.
        force_val = 8'b0000_0101; force_en = 1'b1;
        e = '{lat: 2, st: 3'b100, therm: 8'h05, cnt: 1, terr: 1'b1,
              incs: 0, decs: 0, rsts: 0, init: 8'h00};
        start = done_seen;
        issue(3, 1'b0, e);
        wait_done(start);
        force_en = 1'b0;

        // Step 0 -> 7, aborted after the third inc; stray request while busy.
        run_req(0, 1'b1);
        e = '{lat: 7, st: 3'b001, therm: 8'h07, cnt: 3, terr: 1'b0,
              incs: 3, decs: 0, rsts: 0, init: 8'h00};
        start = done_seen;
        issue(7, 1'b0, e);
        k = 0; n = 0;
        while (k < 3 && n < 40) begin
            @(posedge clk); #2;
            if (ffsr_inc) k++;
            n++;
        end
        if (k < 3) note_fail("third_inc_timeout");
        abort = 1'b1;
        req_valid = 1'b1; req_target = 4'd1; req_load = 1'b1;
        chk("busy_not_ready", 32'(req_ready), 32'd0);
        @(posedge clk); #2;
        abort = 1'b0; req_valid = 1'b0;
        wait_done(start);
        ref_val = 3;

        for (int i = 0; i < 16; i++) begin
            run_req(int'($urandom_range(0, 12)), 1'($urandom_range(0, 1)));
        end

        repeat (4) @(posedge clk);
        chk("queue_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule
